// File: rtl/spi_master_tx_if.sv
// Bundle for the SPI initiator: byte-in stream, byte-out stream, SPI pins and status.
// No logic and no latency; wires only.
// in_val/in_rdy throttle the initiator's input, val/rdy throttle its output.
interface spi_master_tx_if;
  logic [7:0] data_in;
  logic       in_last;
  logic       in_val;
  logic       in_rdy;
  logic       sclk;
  logic       cs;
  logic       mosi;
  logic       miso;
  logic [7:0] data_out;
  logic       val;
  logic       rdy;
  logic       overrun;

  // Initiator's view of the bundle.
  modport master (
    input  data_in, in_last, in_val, miso, rdy,
    output in_rdy, sclk, cs, mosi, data_out, val, overrun
  );

  // Environment's view: feeds bytes in, drives miso, consumes received bytes.
  modport slave (
    output data_in, in_last, in_val, miso, rdy,
    input  in_rdy, sclk, cs, mosi, data_out, val, overrun
  );
endinterface

// File: rtl/spi_master_tx.sv
// SPI mode-0 initiator: serialises bytes MSB-first on mosi and captures miso full duplex.
// Latency: cs/mosi one cycle after accept; received byte valid 1+16*CLK_DIV cycles after accept.
// in_rdy only in IDLE/WAIT; a byte completing while val is held off is dropped and flagged.
module spi_master_tx #(
  parameter int CLK_DIV = 5
) (
  input  logic           clk,
  input  logic           rst,
  spi_master_tx_if.master bus
);

  localparam int            CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_WAIT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [2:0]    r_bit;
  logic [2:0]    w_bit_nxt;

  // r_tx[7] is the mosi pin itself, so mosi is registered and holds bit0 after the last shift.
  logic [7:0]    r_tx;
  logic [6:0]    r_rx;
  logic          r_last;
  logic          r_sclk;
  logic          r_cs;
  logic          r_in_rdy;
  logic [7:0]    r_data_out;
  logic          r_val;
  logic          r_overrun;

  logic          w_accept;
  logic          w_load;
  logic          w_shift_tx;
  logic          w_sample;
  logic          w_done;
  logic          w_cs_nxt;
  logic          w_sclk_nxt;
  logic          w_in_rdy_nxt;
  logic [7:0]    w_rx_byte;

  // in_rdy is registered from the next state, so it is already 0 in SETUP..GAP.
  assign w_accept  = bus.in_val && r_in_rdy;
  assign w_rx_byte = {r_rx, bus.miso};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, phase timing, bit position and the registered-pin values of the next state.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = (r_cnt == '0) ? r_cnt : r_cnt - CNT_ONE;
    w_bit_nxt   = r_bit;
    w_load      = 1'b0;
    w_shift_tx  = 1'b0;
    w_sample    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE, S_WAIT: begin
        if (w_accept) begin
          w_state_nxt = S_SETUP;
          w_cnt_nxt   = CNT_LOAD;
          w_load      = 1'b1;
        end
      end
      S_SETUP, S_LOW: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_HIGH;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      S_HIGH: begin
        if (r_cnt == '0) begin
          w_sample  = 1'b1;
          w_cnt_nxt = CNT_LOAD;
          if (r_bit == 3'd7) begin
            // Final bit: no LOW phase, sclk falls straight into HOLD or WAIT.
            w_done      = 1'b1;
            w_bit_nxt   = 3'd0;
            w_state_nxt = r_last ? S_HOLD : S_WAIT;
          end else begin
            w_bit_nxt   = r_bit + 3'd1;
            w_shift_tx  = 1'b1;
            w_state_nxt = S_LOW;
          end
        end
      end
      S_HOLD: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      S_GAP: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_cs_nxt     = (w_state_nxt == S_IDLE) || (w_state_nxt == S_GAP);
    w_sclk_nxt   = (w_state_nxt == S_HIGH);
    w_in_rdy_nxt = (w_state_nxt == S_IDLE) || (w_state_nxt == S_WAIT);
  end

  // Counters, shift registers and registered SPI pins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_bit    <= '0;
      r_tx     <= '0;
      r_rx     <= '0;
      r_last   <= 1'b0;
      r_sclk   <= 1'b0;
      r_cs     <= 1'b1;
      r_in_rdy <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_bit    <= w_bit_nxt;
      r_sclk   <= w_sclk_nxt;
      r_cs     <= w_cs_nxt;
      r_in_rdy <= w_in_rdy_nxt;
      if (w_load) begin
        r_tx   <= bus.data_in;
        r_last <= bus.in_last;
      end else if (w_shift_tx) begin
        r_tx   <= {r_tx[6:0], 1'b0};
      end
      if (w_sample) begin
        r_rx <= w_rx_byte[6:0];
      end
    end
  end

  // Received-byte output register: a pop in the same cycle frees the slot for the new byte.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_data_out <= '0;
      r_val      <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_done) begin
        if (!r_val || bus.rdy) begin
          r_data_out <= w_rx_byte;
          r_val      <= 1'b1;
        end else begin
          r_overrun  <= 1'b1;
        end
      end else if (r_val && bus.rdy) begin
        r_val <= 1'b0;
      end
    end
  end

  assign bus.sclk     = r_sclk;
  assign bus.cs       = r_cs;
  assign bus.mosi     = r_tx[7];
  assign bus.in_rdy   = r_in_rdy;
  assign bus.data_out = r_data_out;
  assign bus.val      = r_val;
  assign bus.overrun  = r_overrun;

endmodule

// File: tb/tb_spi_master_tx.sv
// Directed bench for spi_master_tx: a CLK_DIV=5 instance against a mode-0 responder model,
// and a CLK_DIV=2 instance with miso looped back from mosi.
// Inputs change and outputs are sampled 1 time unit after the rising clk edge.
module tb_spi_master_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_master_tx_if u_if5 ();
  spi_master_tx_if u_if2 ();

  spi_master_tx #(.CLK_DIV(5)) u_dut5 (.clk(clk), .rst(rst), .bus(u_if5.master));
  spi_master_tx #(.CLK_DIV(2)) u_dut2 (.clk(clk), .rst(rst), .bus(u_if2.master));

  int checks = 0;
  int errors = 0;

  // Responder model (mode 0) on the CLK_DIV=5 instance, plus edge/cycle monitors.
  logic [7:0] resp_pat   = 8'h00;
  logic [7:0] resp_tx    = 8'h00;
  logic [7:0] resp_rx    = 8'h00;
  logic [2:0] resp_bits  = 3'd0;
  logic [7:0] resp_mem [0:31];
  int         resp_cnt   = 0;
  logic       prev_sclk5 = 1'b0;
  logic       prev_cs5   = 1'b1;
  logic       prev_mosi5 = 1'b0;
  logic       prev_mosi2 = 1'b0;
  int         rise5      = 0;
  int         cslow5     = 0;
  int         csrise5    = 0;
  int         viol5      = 0;
  int         viol2      = 0;
  int         cyc        = 0;

  assign u_if5.miso = resp_tx[7];
  assign u_if2.miso = u_if2.mosi;

  // Responder: capture mosi on sclk rise, advance miso after sclk fall, reload per byte.
  always @(posedge clk) begin
    prev_sclk5 <= u_if5.sclk;
    prev_cs5   <= u_if5.cs;
    prev_mosi5 <= u_if5.mosi;
    prev_mosi2 <= u_if2.mosi;
    cyc        <= cyc + 1;
    if (u_if5.cs === 1'b1) begin
      resp_tx   <= resp_pat;
      resp_bits <= 3'd0;
    end else if (u_if5.cs === 1'b0) begin
      if (u_if5.sclk && !prev_sclk5) begin
        resp_rx   <= {resp_rx[6:0], u_if5.mosi};
        resp_bits <= resp_bits + 3'd1;
        if (resp_bits == 3'd7) begin
          resp_mem[resp_cnt[4:0]] <= {resp_rx[6:0], u_if5.mosi};
          resp_cnt <= resp_cnt + 1;
        end
      end
      if (!u_if5.sclk && prev_sclk5) begin
        if (resp_bits == 3'd0) resp_tx <= resp_pat;
        else                   resp_tx <= {resp_tx[6:0], 1'b0};
      end
    end
    if (u_if5.sclk === 1'b1 && prev_sclk5 === 1'b0) rise5 <= rise5 + 1;
    if (u_if5.cs === 1'b0) cslow5 <= cslow5 + 1;
    if (u_if5.cs === 1'b1 && prev_cs5 === 1'b0) csrise5 <= csrise5 + 1;
    if (u_if5.sclk === 1'b1 && u_if5.mosi !== prev_mosi5) viol5 <= viol5 + 1;
    if (u_if2.sclk === 1'b1 && u_if2.mosi !== prev_mosi2) viol2 <= viol2 + 1;
  end

  function automatic logic [7:0] resp_at(input int k);
    return resp_mem[k[4:0]];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_rdy5(input string tag);
    int n;
    n = 0;
    while (u_if5.in_rdy !== 1'b1 && n < 3000) begin
      step(1);
      n++;
    end
    check(tag, u_if5.in_rdy, 1);
  endtask

  task automatic wait_rdy2(input string tag);
    int n;
    n = 0;
    while (u_if2.in_rdy !== 1'b1 && n < 3000) begin
      step(1);
      n++;
    end
    check(tag, u_if2.in_rdy, 1);
  endtask

  // Returns at T0+1, one cycle after the accept edge.
  task automatic send5(input logic [7:0] b, input logic last);
    wait_rdy5("in_rdy5_timeout");
    u_if5.data_in = b;
    u_if5.in_last = last;
    u_if5.in_val  = 1'b1;
    step(1);
    u_if5.in_val  = 1'b0;
  endtask

  task automatic send2(input logic [7:0] b, input logic last);
    wait_rdy2("in_rdy2_timeout");
    u_if2.data_in = b;
    u_if2.in_last = last;
    u_if2.in_val  = 1'b1;
    step(1);
    u_if2.in_val  = 1'b0;
  endtask

  initial begin
    int r0, c0, k0, s0, t_a, t_b;
    logic [7:0] rb [0:5];

    rst = 1'b0;
    u_if5.data_in = 8'h00; u_if5.in_last = 1'b0; u_if5.in_val = 1'b0; u_if5.rdy = 1'b1;
    u_if2.data_in = 8'h00; u_if2.in_last = 1'b0; u_if2.in_val = 1'b0; u_if2.rdy = 1'b1;

    // Reset state.
    step(3);
    check("rst_cs", u_if5.cs, 1);
    check("rst_sclk", u_if5.sclk, 0);
    check("rst_mosi", u_if5.mosi, 0);
    check("rst_in_rdy", u_if5.in_rdy, 0);
    check("rst_val", u_if5.val, 0);
    check("rst_data_out", u_if5.data_out, 0);
    check("rst_overrun", u_if5.overrun, 0);
    rst = 1'b1;
    step(1);
    check("rel_in_rdy", u_if5.in_rdy, 1);

    // Single last byte 0xA5 out, 0x3C returned by the responder.
    resp_pat = 8'h3C;
    r0 = rise5; c0 = cslow5; k0 = resp_cnt;
    send5(8'hA5, 1'b1);
    check("t1_cs_low", u_if5.cs, 0);
    check("t1_mosi_bit7", u_if5.mosi, 1);
    check("t1_in_rdy", u_if5.in_rdy, 0);
    step(5);
    check("t6_sclk_rise", u_if5.sclk, 1);
    step(74);
    check("t80_sclk", u_if5.sclk, 1);
    check("t80_val", u_if5.val, 0);
    step(1);
    check("t81_sclk", u_if5.sclk, 0);
    check("t81_val", u_if5.val, 1);
    check("t81_data_out", u_if5.data_out, 8'h3C);
    step(1);
    check("t82_val_pop", u_if5.val, 0);
    step(3);
    check("t85_cs", u_if5.cs, 0);
    step(1);
    check("t86_cs", u_if5.cs, 1);
    step(4);
    check("t90_in_rdy", u_if5.in_rdy, 0);
    step(1);
    check("t91_in_rdy", u_if5.in_rdy, 1);
    check("a5_rises", rise5 - r0, 8);
    check("a5_cs_low_cycles", cslow5 - c0, 85);
    check("a5_resp_count", resp_cnt - k0, 1);
    check("a5_resp_byte", resp_at(k0), 8'hA5);

    // Three-byte frame, cs held low throughout, back-to-back at the minimum period.
    r0 = rise5; c0 = csrise5; k0 = resp_cnt;
    send5(8'h01, 1'b0);
    t_a = cyc;
    send5(8'h80, 1'b0);
    t_b = cyc;
    check("b2b_period", t_b - t_a, 81);
    send5(8'hFF, 1'b1);
    wait_rdy5("frame_end_timeout");
    check("frame_rises", rise5 - r0, 24);
    check("frame_cs_rises", csrise5 - c0, 1);
    check("frame_byte0", resp_at(k0), 8'h01);
    check("frame_byte1", resp_at(k0 + 1), 8'h80);
    check("frame_byte2", resp_at(k0 + 2), 8'hFF);

    // Overrun: hold rdy low across two received bytes.
    u_if5.rdy = 1'b0;
    resp_pat = 8'h11;
    send5(8'h00, 1'b1);
    wait_rdy5("ovr1_timeout");
    check("ovr1_val", u_if5.val, 1);
    check("ovr1_data", u_if5.data_out, 8'h11);
    check("ovr1_flag", u_if5.overrun, 0);
    resp_pat = 8'h22;
    send5(8'h00, 1'b1);
    step(80);
    check("ovr2_val", u_if5.val, 1);
    check("ovr2_data_kept", u_if5.data_out, 8'h11);
    check("ovr2_flag", u_if5.overrun, 1);
    u_if5.rdy = 1'b1;
    step(1);
    check("ovr_pop_val", u_if5.val, 0);
    check("ovr_sticky", u_if5.overrun, 1);
    wait_rdy5("ovr_end_timeout");

    // Reset in the middle of the 4th bit of 0xF0.
    send5(8'hF0, 1'b1);
    step(37);
    check("mid_sclk_high", u_if5.sclk, 1);
    rst = 1'b0;
    step(1);
    check("mid_rst_cs", u_if5.cs, 1);
    check("mid_rst_sclk", u_if5.sclk, 0);
    check("mid_rst_mosi", u_if5.mosi, 0);
    check("mid_rst_val", u_if5.val, 0);
    check("mid_rst_in_rdy", u_if5.in_rdy, 0);
    check("mid_rst_overrun", u_if5.overrun, 0);
    check("mid_rst_data_out", u_if5.data_out, 0);
    rst = 1'b1;
    step(1);
    check("mid_rel_in_rdy", u_if5.in_rdy, 1);
    resp_pat = 8'hC3;
    k0 = resp_cnt;
    send5(8'h5A, 1'b1);
    step(80);
    check("post_rst_val", u_if5.val, 1);
    check("post_rst_data", u_if5.data_out, 8'hC3);
    wait_rdy5("post_rst_timeout");
    check("post_rst_resp_count", resp_cnt - k0, 1);
    check("post_rst_resp_byte", resp_at(k0), 8'h5A);

    // Random bytes on both instances; mosi must hold while sclk is high.
    for (int i = 0; i < 6; i++) rb[i] = 8'($urandom_range(0, 255));
    k0 = resp_cnt;
    for (int i = 0; i < 3; i++) begin
      resp_pat = 8'h96;
      send5(rb[i], (i == 2));
    end
    wait_rdy5("rand5_timeout");
    for (int i = 0; i < 3; i++) begin
      check("rand5_resp_byte", resp_at(k0 + i), rb[i]);
    end
    for (int i = 0; i < 6; i++) begin
      send2(rb[i], (i == 5));
      step(32);
      check("rand2_val", u_if2.val, 1);
      check("rand2_loop_data", u_if2.data_out, rb[i]);
    end
    wait_rdy2("rand2_end_timeout");
    s0 = viol5;
    check("mosi_stable_d5", s0, 0);
    check("mosi_stable_d2", viol2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master_tx.md
# spi_master_tx

SPI mode-0 initiator that is the transmit-side counterpart of `spiModule` (SPI responder). Accepts bytes over a val/rdy stream and serialises them MSB-first on `mosi` while generating `sclk` and `cs`. Captures `miso` in full duplex and returns the received byte over a second val/rdy stream. Bytes may be grouped into multi-byte frames, with `cs` held low between bytes.

## Interface
- `CLK_DIV`, default 5: length of each `sclk` half-period in `clk` cycles. Must be ≥2. The default gives `sclk` = clk/10.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-low reset; sampled on the `clk` rising edge, asserted when 0.
- `data_in`  in  8  byte to transmit.
- `in_last`  in  1  qualifies `data_in`; 1 = final byte of the frame, so `cs` is released after it.
- `in_val`  in  1  `data_in`/`in_last` valid.
- `in_rdy`  out  1  block can accept a byte.
- `sclk`  out  1  SPI clock; CPOL=0; registered.
- `cs`  out  1  chip select, active-low; registered.
- `mosi`  out  1  serial data out; registered.
- `miso`  in  1  serial data in; already synchronous to `clk`.
- `data_out`  out  8  received byte.
- `val`  out  1  `data_out` valid.
- `rdy`  in  1  downstream accepts `data_out`.
- `overrun`  out  1  sticky flag: a received byte was dropped.

## Operation
- FSM states: IDLE, SETUP, HIGH, LOW, WAIT, HOLD, GAP. A single down-counter of width clog2(CLK_DIV) times each phase. A 3-bit bit counter tracks bit position.
- **IDLE**
  - `cs`=1, `sclk`=0, `in_rdy`=1.
  - On `in_val`&`in_rdy`: latch `data_in` into the tx shift register and latch `in_last`.
  - Go to SETUP.
- **SETUP** (CLK_DIV cycles): `cs`=0, `mosi`=bit7, `sclk`=0.
- **HIGH** (CLK_DIV cycles): `sclk`=1.
  - On the edge leaving HIGH, `miso` is shifted into the rx register LSB-side; this is the value held during the high phase.
- **LOW**
  - `sclk`=0.
  - On entry, `mosi` presents the next bit.
  - After CLK_DIV cycles, go to HIGH.
  - After the 8th HIGH, skip LOW and go to HOLD if `in_last` was latched, otherwise to WAIT.
- **WAIT**
  - `cs`=0, `sclk`=0, `mosi` holds bit0, `in_rdy`=1.
  - On accept: latch the new byte and go to SETUP. `cs` is not deasserted.
- **HOLD** (CLK_DIV cycles): `cs`=0, `sclk`=0.
- **GAP** (CLK_DIV cycles): `cs`=1, `in_rdy`=0. Then go to IDLE.
- `in_rdy`=1 only in IDLE and WAIT.
- **Receive path**
  - The completed rx byte is loaded into `data_out` on the same edge that drops `sclk` after bit0, and `val` is set.
  - `val` clears on `val`&`rdy`.
  - If a new byte completes while `val`=1 and `rdy`=0: the new byte is discarded, `data_out` keeps the old byte, and `overrun` is set.
  - If `val`&`rdy` coincides with a new byte completing: the new byte loads and `val` stays 1. There is no overrun.
  - `overrun` clears only on reset.
- **Reset** (`rst`=0), from any state, mid-frame included: on the next edge `cs`=1, `sclk`=0, `mosi`=0, `in_rdy`=0, `val`=0, `data_out`=0, `overrun`=0, state=IDLE. `in_rdy` rises on the first edge with `rst`=1.

## Timing
- Let T0 be the accept cycle and D = CLK_DIV. Outputs are registered.
  - T0+1: `cs`=0 and `mosi`=bit7.
  - Bit j (j=0 is the MSB) has `sclk` high from T0+1+D(1+2j) through T0+D(2+2j).
  - `sclk` falls for the last time at T0+1+16D. `val` rises in that same cycle.
- Last byte:
  - `cs` rises at T0+1+17D.
  - `in_rdy` rises at T0+1+18D.
  - With D=5: `cs` rises at T0+86, `in_rdy` at T0+91.
- Not last:
  - `in_rdy`=1 from T0+1+16D.
  - A byte accepted at T1 follows the same schedule relative to T1.
  - Minimum back-to-back byte period is 16D+1.
- `mosi` changes only while `sclk`=0, at least D cycles before a rising edge. `cs` falls at least D cycles before the first rising edge and rises D cycles after the last falling edge.

## Test plan
- Reset, then send 0xA5 with `in_last`=1 and D=5; the `spiModule` responder has `rdy`=1 → the responder `data_out`=0xA5 with one `val` pulse; `cs` is low for exactly 85 cycles; exactly 8 `sclk` rising edges; `in_rdy` returns at T0+91.
- Loop `miso` from a responder model shifting 0x3C → `data_out`=0x3C, with `val` at T0+81.
- Send a frame 0x01, 0x80, 0xFF where only the last byte has `in_last`=1 → `cs` stays low across all 3 bytes; 24 rising edges; the responder receives the 3 bytes in order.
- Hold `rdy`=0 and receive two bytes (0x11, then 0x22) → `data_out`=0x11 and `overrun`=1. Then `rdy`=1 → `val` drops after one cycle and `overrun` stays 1.
- Pull `rst` low during the 4th bit of 0xF0 → next edge `cs`=1, `sclk`=0, `val`=0, `in_rdy`=0. After release, sending 0x5A is received intact.
- Check `mosi` stability: assert `mosi` never toggles while `sclk`=1 across random bytes with D=2 and D=5.
